// File: rtl/strand_address_generator_if.sv
// strand_address_generator_if: start/config inputs and the address stream of the strand address generator.
interface strand_address_generator_if #(
    parameter int MEM_ADDR_WIDTH = 24,
    parameter int LEN_WIDTH = 10,
    parameter int IDX_WIDTH = 2
);
    logic start;
    logic abort;
    logic buf_sel;
    logic [LEN_WIDTH-1:0] strand_len;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic addr_valid;
    logic addr_ready;
    logic [IDX_WIDTH-1:0] strand_idx;
    logic strand_last;
    logic frame_last;
    logic busy;
    logic done;
    modport master (
        input start, abort, buf_sel, strand_len, addr_ready,
        output addr, addr_valid, strand_idx, strand_last, frame_last, busy, done
    );
    modport slave (
        output start, abort, buf_sel, strand_len, addr_ready,
        input addr, addr_valid, strand_idx, strand_last, frame_last, busy, done
    );
endinterface

// File: rtl/strand_address_generator.sv
// strand_address_generator: walks a frame buffer strand by strand, one byte address per valid/ready beat.
module strand_address_generator #(
    parameter int MEM_ADDR_WIDTH = 24,
    parameter int NUM_STRANDS = 4,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int LEN_WIDTH = 10,
    parameter int STRAND_STRIDE = 'h600,
    parameter logic [MEM_ADDR_WIDTH-1:0] FRAME_BASE_A = 'h000000,
    parameter logic [MEM_ADDR_WIDTH-1:0] FRAME_BASE_B = 'h001800
) (
    input logic clk,
    input logic rst,
    strand_address_generator_if.master bus
);
    localparam int IDX_WIDTH = NUM_STRANDS > 1 ? $clog2(NUM_STRANDS) : 1;
    localparam int MAX_LEN = STRAND_STRIDE / BYTES_PER_PIXEL;
    localparam int OFF_WIDTH = $clog2(STRAND_STRIDE + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_STRANDS - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] STRIDE = MEM_ADDR_WIDTH'(STRAND_STRIDE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_n;
    logic [MEM_ADDR_WIDTH-1:0] base, base_n;
    logic [OFF_WIDTH-1:0] off, off_n, strand_bytes, strand_bytes_n;
    logic [IDX_WIDTH-1:0] idx, idx_n;
    logic done_q, done_n, end_strand, run;
    int len_c;

    assign run = state == RUN;
    assign end_strand = off == strand_bytes - OFF_WIDTH'(1);
    // base accumulates the strand stride, so the address is just base plus the byte offset
    assign bus.addr = base + MEM_ADDR_WIDTH'(off);
    assign bus.addr_valid = run;
    assign bus.busy = run;
    assign bus.strand_idx = idx;
    assign bus.strand_last = run && end_strand;
    assign bus.frame_last = run && end_strand && idx == LAST_IDX;
    assign bus.done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base <= '0;
            off <= '0;
            idx <= '0;
            strand_bytes <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            base <= base_n;
            off <= off_n;
            idx <= idx_n;
            strand_bytes <= strand_bytes_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        base_n = base;
        off_n = off;
        idx_n = idx;
        strand_bytes_n = strand_bytes;
        done_n = 1'b0;
        len_c = int'(bus.strand_len) > MAX_LEN ? MAX_LEN : int'(bus.strand_len);
        if (state == IDLE) begin
            if (bus.start && bus.strand_len != '0) begin
                state_n = RUN;
                base_n = bus.buf_sel ? FRAME_BASE_B : FRAME_BASE_A;
                off_n = '0;
                idx_n = '0;
                strand_bytes_n = OFF_WIDTH'(len_c * BYTES_PER_PIXEL);
            end else if (bus.start) begin
                done_n = 1'b1;
            end
        end else if (bus.abort) begin
            state_n = IDLE;
        end else if (bus.addr_ready) begin
            if (!end_strand) begin
                off_n = off + OFF_WIDTH'(1);
            end else if (idx != LAST_IDX) begin
                off_n = '0;
                idx_n = idx + IDX_WIDTH'(1);
                base_n = base + STRIDE;
            end else begin
                state_n = IDLE;
                done_n = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_strand_address_generator.sv
// tb_strand_address_generator: randomized walks checked against a frame/strand/byte address model.
module tb_strand_address_generator;
    localparam int AW = 24, NS = 4, BPP = 3, LW = 10, IW = 2, STRIDE = 'h600;
    localparam int MAX_LEN = STRIDE / BPP;
    localparam logic [AW-1:0] FB_A = 24'h000000, FB_B = 24'h001800, FB_W = 24'hFFFFFE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    strand_address_generator_if #(.MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) b ();
    strand_address_generator_if #(.MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) w ();

    strand_address_generator #(
        .MEM_ADDR_WIDTH(AW), .NUM_STRANDS(NS), .BYTES_PER_PIXEL(BPP), .LEN_WIDTH(LW),
        .STRAND_STRIDE(STRIDE), .FRAME_BASE_A(FB_A), .FRAME_BASE_B(FB_B)
    ) dut (.clk(clk), .rst(rst), .bus(b));

    strand_address_generator #(
        .MEM_ADDR_WIDTH(AW), .NUM_STRANDS(NS), .BYTES_PER_PIXEL(BPP), .LEN_WIDTH(LW),
        .STRAND_STRIDE(STRIDE), .FRAME_BASE_A(FB_A), .FRAME_BASE_B(FB_W)
    ) dut_w (.clk(clk), .rst(rst), .bus(w));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete frame walk; the expected stream is every (strand, byte) pair in order.
    task automatic test_walk(input string tag, input bit sel, input int len, input int pct,
                             input int stall_at, input bit pre, input bit ab, input bit poke,
                             input bit chain, input bit nsel, input int nlen);
        logic [AW-1:0] qa[$];
        bit qs[$], qf[$];
        int qi[$];
        int nbytes, i, cyc, stalls;
        bit stl;
        nbytes = (len > MAX_LEN ? MAX_LEN : len) * BPP;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < nbytes; k++) begin
                qa.push_back((sel ? FB_B : FB_A) + AW'(s * STRIDE) + AW'(k));
                qs.push_back(k == nbytes - 1);
                qf.push_back(k == nbytes - 1 && s == NS - 1);
                qi.push_back(s);
            end
        if (!pre) begin
            b.start = 1'b1;
            b.buf_sel = sel;
            b.strand_len = LW'(len);
            b.abort = ab;
        end
        tick;
        b.start = 1'b0;
        b.abort = 1'b0;
        i = 0;
        cyc = 0;
        stalls = 0;
        while (i < qa.size() && cyc < 20000) begin
            stl = i == stall_at && stalls < 3;
            if (stl) stalls++;
            b.addr_ready = stl ? 1'b0 : ($urandom_range(99) < pct);
            b.start = poke && i == 1;
            b.buf_sel = (poke && i == 1) ? !sel : sel;
            b.strand_len = (poke && i == 1) ? LW'(5) : LW'(len);
            n_assert++;
            if (b.addr_valid !== 1'b1 || b.busy !== 1'b1 || b.addr !== qa[i] || b.strand_last !== qs[i] ||
                b.frame_last !== qf[i] || int'(b.strand_idx) != qi[i] || b.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s beat %0d: got v=%b busy=%b addr=%h idx=%0d sl=%b fl=%b done=%b, want v=1 busy=1 addr=%h idx=%0d sl=%b fl=%b done=0",
                         tag, i, b.addr_valid, b.busy, b.addr, b.strand_idx, b.strand_last, b.frame_last, b.done,
                         qa[i], qi[i], qs[i], qf[i]);
            end
            if (b.addr_ready) i++;
            tick;
            cyc++;
        end
        b.start = 1'b0;
        b.buf_sel = sel;
        if (cyc >= 20000) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats, want %0d", tag, i, qa.size());
        end
        if (chain) begin
            b.start = 1'b1;
            b.buf_sel = nsel;
            b.strand_len = LW'(nlen);
        end
        n_assert++;
        if (b.addr_valid !== 1'b0 || b.busy !== 1'b0 || b.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: got v=%b busy=%b done=%b, want v=0 busy=0 done=1",
                     tag, b.addr_valid, b.busy, b.done);
        end
        if (!chain) begin
            tick;
            n_assert++;
            if (b.addr_valid !== 1'b0 || b.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after end: got v=%b done=%b, want v=0 done=0", tag, b.addr_valid, b.done);
            end
        end
    endtask

    task automatic test_reset;
        int cyc;
        #1 rst = 1'b1;
        #1;
        n_assert++;
        if ({b.addr, b.addr_valid, b.strand_idx, b.strand_last, b.frame_last, b.busy, b.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h v=%b busy=%b done=%b, want all 0",
                     b.addr, b.addr_valid, b.busy, b.done);
        end
        tick;
        rst = 1'b0;
        tick;
        b.addr_ready = 1'b1;
        b.buf_sel = 1'b0;
        b.strand_len = LW'(2);
        b.start = 1'b1;
        tick;
        b.start = 1'b0;
        cyc = 0;
        while (b.addr !== 24'h000603 && cyc < 50) begin
            tick;
            cyc++;
        end
        n_assert++;
        if (b.addr !== 24'h000603 || b.addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reach: got addr=%h v=%b, want addr=000603 v=1", b.addr, b.addr_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if (b.addr !== '0 || b.addr_valid !== 1'b0 || b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got addr=%h v=%b busy=%b, want 0 0 0", b.addr, b.addr_valid, b.busy);
        end
        tick;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_assert++;
            if (b.done !== 1'b0 || b.addr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done: got done=%b v=%b, want 0 0", b.done, b.addr_valid);
            end
        end
        test_walk("reset_restart", 1'b0, 2, 100, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_abort;
        int cyc;
        b.addr_ready = 1'b1;
        b.buf_sel = 1'b0;
        b.strand_len = LW'(2);
        b.start = 1'b1;
        tick;
        b.start = 1'b0;
        cyc = 0;
        while (b.addr !== 24'h000604 && cyc < 50) begin
            tick;
            cyc++;
        end
        b.abort = 1'b1;
        tick;
        b.abort = 1'b0;
        n_assert++;
        if (b.addr_valid !== 1'b0 || b.busy !== 1'b0 || b.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mid: got v=%b busy=%b done=%b, want 0 0 0", b.addr_valid, b.busy, b.done);
        end
        test_walk("abort_restart", 1'b0, 2, 100, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        b.addr_ready = 1'b1;
        b.strand_len = LW'(1);
        b.start = 1'b1;
        tick;
        b.start = 1'b0;
        cyc = 0;
        while (b.frame_last !== 1'b1 && cyc < 50) begin
            tick;
            cyc++;
        end
        b.abort = 1'b1;
        tick;
        b.abort = 1'b0;
        n_assert++;
        if (b.addr_valid !== 1'b0 || b.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final: got v=%b done=%b, want 0 0", b.addr_valid, b.done);
        end
        tick;
        n_assert++;
        if (b.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final_late: got done=%b, want 0", b.done);
        end
    endtask

    task automatic test_idle_abort;
        b.abort = 1'b1;
        tick;
        tick;
        b.abort = 1'b0;
        n_assert++;
        if (b.addr_valid !== 1'b0 || b.busy !== 1'b0 || b.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort: got v=%b busy=%b done=%b, want 0 0 0", b.addr_valid, b.busy, b.done);
        end
        test_walk("start_beats_abort", 1'b0, 2, 100, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp;
        w.addr_ready = 1'b1;
        w.buf_sel = 1'b1;
        w.strand_len = LW'(1);
        w.start = 1'b1;
        tick;
        w.start = 1'b0;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < BPP; k++) begin
                exp = FB_W + AW'(s * STRIDE) + AW'(k);
                n_assert++;
                if (w.addr_valid !== 1'b1 || w.addr !== exp) begin
                    n_fail++;
                    $display("FAIL wrap s%0d k%0d: got v=%b addr=%h, want v=1 addr=%h", s, k, w.addr_valid, w.addr, exp);
                end
                tick;
            end
        n_assert++;
        if (w.addr_valid !== 1'b0 || w.done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end: got v=%b done=%b, want v=0 done=1", w.addr_valid, w.done);
        end
        tick;
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++)
            test_walk("random", 1'($urandom_range(1)), int'($urandom_range(40)), int'($urandom_range(100, 30)),
                      int'($urandom_range(20)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        b.start = 1'b0; b.abort = 1'b0; b.buf_sel = 1'b0; b.strand_len = '0; b.addr_ready = 1'b0;
        w.start = 1'b0; w.abort = 1'b0; w.buf_sel = 1'b0; w.strand_len = '0; w.addr_ready = 1'b0;
        test_reset;
        test_walk("basic", 1'b0, 2, 100, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        test_walk("clamp_buf_b", 1'b1, 600, 100, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        test_walk("backpressure", 1'b0, 2, 100, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        test_walk("zero_len", 1'b0, 0, 100, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        test_walk("ignored_start", 1'b1, 3, 70, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        test_abort;
        test_idle_abort;
        test_walk("back_to_back_1", 1'b0, 1, 100, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        test_walk("back_to_back_2", 1'b1, 2, 100, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        test_random;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/strand_address_generator.md
Name: strand_address_generator

Overview:
- Parametrised successor to the single-stream memory address generator.
- Walks the frame buffer strand by strand, producing one byte address per beat on a valid/ready stream for the pixel output engines.
- Generalised in address width, strand count, pixel size and strand stride.
- Adds runtime strand length, double-buffered frame base select, backpressure, abort, and per-strand/frame markers.

Parameters:
- MEM_ADDR_WIDTH, 24, width of memory byte address.
- NUM_STRANDS, 4, number of strands walked per frame (>=1).
- BYTES_PER_PIXEL, 3, bytes fetched per pixel (>=1).
- LEN_WIDTH, 10, width of runtime strand length input.
- STRAND_STRIDE, 'h600, byte distance between consecutive strand regions.
- FRAME_BASE_A, 'h000000, frame buffer A base address.
- FRAME_BASE_B, 'h001800, frame buffer B base address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a frame walk; sampled only in IDLE.
- abort  in  1  synchronous abort of current walk.
- buf_sel  in  1  0 = FRAME_BASE_A, 1 = FRAME_BASE_B; latched on accepted start.
- strand_len  in  LEN_WIDTH  pixels per strand; latched on accepted start.
- addr  out  MEM_ADDR_WIDTH  current byte address.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts the beat when valid && ready.
- strand_idx  out  clog2(NUM_STRANDS) (min 1)  strand of current beat.
- strand_last  out  1  current beat is the last byte of its strand.
- frame_last  out  1  current beat is the last byte of the frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a walk completes normally.

Behaviour:
- Reset (async, rst=1): all outputs 0 immediately; state IDLE; latched config cleared. Reset mid-walk discards the walk with no done.
- Length handling: MAX_LEN = STRAND_STRIDE / BYTES_PER_PIXEL (512 at defaults). strand_len > MAX_LEN is clamped to MAX_LEN at latch time.
- Strand byte count: strand_bytes = clamped_len * BYTES_PER_PIXEL, computed once at start.
- Address: addr = frame_base + strand_idx*STRAND_STRIDE + byte_off, with byte_off in 0..strand_bytes-1. Implemented with an accumulating strand base; no runtime multiplier is required. Arithmetic is modulo 2^MEM_ADDR_WIDTH and wraps silently.
- IDLE:
  - start=1 and strand_len!=0: latch config, go to RUN. addr_valid rises the next cycle with addr = frame_base, strand_idx = 0.
  - start=1 and strand_len==0: no beats; done pulses the next cycle; remain in IDLE.
- RUN: on each beat (valid && ready):
  - If not last of strand: byte_off+1.
  - Else if not last strand: byte_off=0, strand_idx+1, strand base += STRAND_STRIDE.
  - Else (frame_last beat): addr_valid=0 next cycle, done=1 for one cycle, return to IDLE.
- Backpressure: while valid && !ready, addr, strand_idx, strand_last and frame_last hold stable. addr_valid never drops without a handshake except on abort or reset.
- Markers: strand_last = valid && byte_off==strand_bytes-1. frame_last = strand_last && strand_idx==NUM_STRANDS-1.
- Throughput: one beat per cycle with ready held high. There is no bubble between strands or before frame end.
- Abort: abort=1 in RUN drops addr_valid and busy next cycle and returns to IDLE with no done. An abort in the same cycle as the final handshake takes priority (no done). abort in IDLE is ignored.
- Start handling:
  - start while busy is ignored.
  - start in the done cycle is accepted (back-to-back frames).
  - start && abort in IDLE: start wins.
- Latency: start to first valid = 1 cycle. Final handshake to done = 1 cycle. Frame bytes = NUM_STRANDS*strand_bytes.

Test Plan:
- Reset: assert rst mid-RUN at addr 0x603 -> addr=0, addr_valid=0, busy=0 asynchronously; no done; next start (len=2, buf_sel=0) begins at 0x000.
- Basic walk: len=2, buf_sel=0, ready=1 -> 24 beats: 0x000..0x005, 0x600..0x605, 0xC00..0xC05, 0x1200..0x1205. strand_last on 0x005/0x605/0xC05/0x1205; frame_last only on 0x1205; done one cycle later.
- Buffer B and clamp: len=600, buf_sel=1 -> clamped to 512; first addr 0x1800, strand 1 starts at 0x1E00, last addr 0x2FFF; 6144 beats total.
- Backpressure: len=2, ready low for 3 cycles while addr=0x002 -> addr holds 0x002 with valid high; sequence resumes 0x003 with no skipped or duplicated address.
- Zero length / ignored start: len=0 -> done one cycle after start, addr_valid never high. Second start while busy -> no effect on sequence.
- Abort: abort at addr 0x604 -> addr_valid=0 next cycle, no done. Immediate new start -> walk restarts at frame_base.
- Wrap: FRAME_BASE_B=24'hFFFFFE, len=1, buf_sel=1 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, then next strand at 0x0005FE.
